// File: rtl/pc_sequencer.sv
// Registered fetch-stage program counter: next PC from ret / call / jump / branch / stall / +STEP, one-cycle latency.
// Defining PC_RAS_EN adds a circular return-address stack; without it call acts as jump and ret is ignored.
module pc_sequencer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned STEP         = 1,
  parameter int unsigned OFF_W        = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pc_valid,
  output logic             redirect,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_underflow
);
  localparam logic [WIDTH-1:0] RV     = RESET_VECTOR[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             do_ret;
  logic             redir_next;
  logic             uflow_next;
  logic             push;
  logic             pop;

  assign pc_plus_step = pc + STEP_W;
  assign off_ext      = WIDTH'($signed(branch_off));
  assign branch_tgt   = pc_plus_step + off_ext;

`ifdef PC_RAS_EN
  localparam int unsigned     PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    top_inc;
  logic [PW:0]      ras_cnt;

  assign do_ret    = ret_en;
  assign top_inc   = top_ptr + 1'b1;
  assign ras_top   = ras_mem[top_ptr];
  assign ras_full  = (ras_cnt == DEPTH_C);
  assign ras_empty = (ras_cnt == '0);

  // Pointer wraps naturally, so a push on a full stack overwrites the oldest link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      ras_cnt <= '0;
    end else if (pc_valid) begin
      if (push) begin
        top_ptr <= top_inc;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        top_ptr <= top_ptr - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pc_valid && push) ras_mem[top_inc] <= pc_plus_step;
  end
`else
  logic unused_ok;

  assign do_ret    = 1'b0;
  assign ras_top   = '0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign unused_ok = ret_en ^ push ^ pop ^ (RAS_DEPTH > 0);
`endif

  always_comb begin
    pc_next    = pc;
    redir_next = 1'b0;
    uflow_next = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (do_ret) begin
      redir_next = 1'b1;
      if (ras_empty) begin
        pc_next    = pc_plus_step;
        uflow_next = 1'b1;
      end else begin
        pc_next = ras_top;
        pop     = 1'b1;
      end
    end else if (call_en) begin
      redir_next = 1'b1;
      pc_next    = jump_target;
      push       = 1'b1;
    end else if (jump_en) begin
      redir_next = 1'b1;
      pc_next    = jump_target;
    end else if (branch_en) begin
      redir_next = 1'b1;
      pc_next    = branch_tgt;
    end else if (!stall) begin
      pc_next = pc_plus_step;
    end
  end

  // The first edge out of reset only marks the PC valid; sequencing starts on the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RV;
      pc_valid      <= 1'b0;
      redirect      <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!pc_valid) begin
      pc_valid      <= 1'b1;
      redirect      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      redirect      <= redir_next;
      ras_underflow <= uflow_next;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WIDTH=8, STEP=1); RAS scenarios follow the PC_RAS_EN build setting.
module tb_pc_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       stall = 0, branch_en = 0, jump_en = 0, call_en = 0, ret_en = 0;
  logic [7:0] branch_off = 0, jump_target = 0;
  logic [7:0] pc, pc_plus_step;
  logic       pc_valid, redirect, ras_full, ras_empty, ras_underflow;
  int         checks = 0, failures = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic       m_redir, m_uflow;
  logic [7:0] m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(8), .STEP(1), .OFF_W(8), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .jump_target(jump_target), .call_en(call_en), .ret_en(ret_en),
    .pc(pc), .pc_plus_step(pc_plus_step), .pc_valid(pc_valid), .redirect(redirect),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_underflow(ras_underflow));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
    branch_off = 0; jump_target = 0;
  endtask

  task automatic goto(input logic [7:0] t);
    clear_in(); jump_en = 1; jump_target = t; tick(); clear_in();
  endtask

  // Applies the documented next-PC rules to the model for one edge with pc_valid=1.
  task automatic model_edge();
    int t;
    m_redir = 0; m_uflow = 0;
`ifdef PC_RAS_EN
    if (ret_en) begin
      m_redir = 1;
      if (m_stack.size() == 0) begin m_pc = m_pc + 8'd1; m_uflow = 1; end
      else m_pc = m_stack.pop_back();
    end else if (call_en) begin
      m_redir = 1;
      m_stack.push_back(m_pc + 8'd1);
      if (m_stack.size() > 4) void'(m_stack.pop_front());
      m_pc = jump_target;
    end
`else
    if (call_en) begin
      m_redir = 1; m_pc = jump_target;
    end
`endif
    else if (jump_en) begin
      m_redir = 1; m_pc = jump_target;
    end else if (branch_en) begin
      m_redir = 1;
      t = int'(m_pc) + 1 + int'($signed(branch_off));
      m_pc = 8'(t & 255);
    end else if (!stall) begin
      m_pc = 8'((int'(m_pc) + 1) % 256);
    end
  endtask

  task automatic test_reset();
    clear_in(); rst = 1; tick();
    checks++; if (pc !== 8'h00 || pc_valid !== 1'b0) begin failures++; $display("FAIL reset_state pc=%h valid=%b exp 00/0", pc, pc_valid); end
    checks++; if (redirect !== 0 || ras_underflow !== 0 || ras_empty !== 1 || ras_full !== 0) begin failures++; $display("FAIL reset_flags redir=%b uf=%b empty=%b full=%b exp 0/0/1/0", redirect, ras_underflow, ras_empty, ras_full); end
    rst = 0; tick();
    checks++; if (pc_valid !== 1'b1 || pc !== 8'h00) begin failures++; $display("FAIL first_edge valid=%b pc=%h exp 1/00", pc_valid, pc); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++; if (pc !== 8'(i)) begin failures++; $display("FAIL seq pc=%h exp %h", pc, 8'(i)); end
    end
    tick(); #2; rst = 1; #1;
    checks++; if (pc !== 8'h00 || pc_valid !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h valid=%b exp 00/0", pc, pc_valid); end
    rst = 0; tick();
    checks++; if (pc_valid !== 1'b1 || pc !== 8'h00) begin failures++; $display("FAIL rereset_edge valid=%b pc=%h exp 1/00", pc_valid, pc); end
  endtask

  task automatic test_wrap_stall();
    goto(8'hFE);
    checks++; if (pc !== 8'hFE || redirect !== 1) begin failures++; $display("FAIL jump_fe pc=%h redir=%b exp fe/1", pc, redirect); end
    tick();
    checks++; if (pc !== 8'hFF || redirect !== 0 || pc_plus_step !== 8'h00) begin failures++; $display("FAIL pc_ff pc=%h redir=%b pps=%h exp ff/0/00", pc, redirect, pc_plus_step); end
    tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap pc=%h exp 00", pc); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 8'h00 || redirect !== 0) begin failures++; $display("FAIL stall pc=%h redir=%b exp 00/0", pc, redirect); end
    end
    clear_in();
  endtask

  task automatic test_branch();
    goto(8'h10);
    branch_en = 1; branch_off = 8'hFC; tick(); clear_in();
    checks++; if (pc !== 8'h0D || redirect !== 1) begin failures++; $display("FAIL branch pc=%h redir=%b exp 0d/1", pc, redirect); end
    tick();
    checks++; if (pc !== 8'h0E || redirect !== 0) begin failures++; $display("FAIL branch_after pc=%h redir=%b exp 0e/0", pc, redirect); end
    goto(8'h10);
    branch_en = 1; branch_off = 8'hFC; stall = 1; tick(); clear_in();
    checks++; if (pc !== 8'h0D || redirect !== 1) begin failures++; $display("FAIL branch_stall pc=%h redir=%b exp 0d/1", pc, redirect); end
  endtask

  task automatic test_jump_vs_branch();
    goto(8'h20);
    jump_en = 1; jump_target = 8'h80; branch_en = 1; branch_off = 8'h05; tick(); clear_in();
    checks++; if (pc !== 8'h80) begin failures++; $display("FAIL jump_vs_branch pc=%h exp 80", pc); end
  endtask

  task automatic test_call_ret();
`ifdef PC_RAS_EN
    logic [7:0] tgt [5];
    logic [7:0] lnk [5];
    tgt = '{8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
    lnk = '{8'h32, 8'h61, 8'h71, 8'h81, 8'h91};
    goto(8'h30);
    call_en = 1; jump_target = 8'h50; tick(); clear_in();
    checks++; if (pc !== 8'h50 || ras_empty !== 0) begin failures++; $display("FAIL call pc=%h empty=%b exp 50/0", pc, ras_empty); end
    ret_en = 1; tick(); clear_in();
    checks++; if (pc !== 8'h31 || ras_empty !== 1) begin failures++; $display("FAIL ret pc=%h empty=%b exp 31/1", pc, ras_empty); end
    for (int i = 0; i < 5; i++) begin
      call_en = 1; jump_target = tgt[i]; tick();
    end
    clear_in();
    checks++; if (ras_full !== 1 || pc !== 8'hA0) begin failures++; $display("FAIL five_calls full=%b pc=%h exp 1/a0", ras_full, pc); end
    for (int i = 4; i >= 1; i--) begin
      ret_en = 1; tick();
      checks++; if (pc !== lnk[i]) begin failures++; $display("FAIL lifo_ret pc=%h exp %h", pc, lnk[i]); end
    end
    tick(); clear_in();
    checks++; if (pc !== 8'h62 || ras_underflow !== 1 || ras_empty !== 1) begin failures++; $display("FAIL underflow pc=%h uf=%b empty=%b exp 62/1/1", pc, ras_underflow, ras_empty); end
    tick();
    checks++; if (ras_underflow !== 0 || pc !== 8'h63) begin failures++; $display("FAIL underflow_pulse uf=%b pc=%h exp 0/63", ras_underflow, pc); end
`else
    goto(8'h30);
    call_en = 1; jump_target = 8'h40; tick(); clear_in();
    checks++; if (pc !== 8'h40 || redirect !== 1 || ras_empty !== 1) begin failures++; $display("FAIL call_as_jump pc=%h redir=%b empty=%b exp 40/1/1", pc, redirect, ras_empty); end
    ret_en = 1; tick();
    checks++; if (pc !== 8'h41 || redirect !== 0 || ras_empty !== 1) begin failures++; $display("FAIL ret_ignored pc=%h redir=%b empty=%b exp 41/0/1", pc, redirect, ras_empty); end
    tick(); clear_in();
    checks++; if (pc !== 8'h42 || ras_underflow !== 0 || ras_full !== 0) begin failures++; $display("FAIL ret_ignored2 pc=%h uf=%b full=%b exp 42/0/0", pc, ras_underflow, ras_full); end
`endif
  endtask

  task automatic test_random();
    logic exp_full, exp_empty;
    clear_in(); rst = 1; tick(); rst = 0; tick();
    m_pc = 8'h00; m_stack.delete();
    for (int n = 0; n < 400; n++) begin
      stall       = ($urandom_range(0, 99) < 25);
      branch_en   = ($urandom_range(0, 99) < 12);
      jump_en     = ($urandom_range(0, 99) < 8);
      call_en     = ($urandom_range(0, 99) < 10);
      ret_en      = ($urandom_range(0, 99) < 10);
      branch_off  = 8'($urandom);
      jump_target = 8'($urandom);
      model_edge();
      tick();
`ifdef PC_RAS_EN
      exp_full = (m_stack.size() == 4); exp_empty = (m_stack.size() == 0);
`else
      exp_full = 0; exp_empty = 1;
`endif
      checks++;
      if (pc !== m_pc || redirect !== m_redir || ras_underflow !== m_uflow || ras_full !== exp_full ||
          ras_empty !== exp_empty || pc_plus_step !== 8'(m_pc + 8'd1)) begin
        failures++;
        $display("FAIL random n=%0d pc=%h/%h redir=%b/%b uf=%b/%b full=%b/%b empty=%b/%b pps=%h (got/exp)",
                 n, pc, m_pc, redirect, m_redir, ras_underflow, m_uflow, ras_full, exp_full, ras_empty, exp_empty, pc_plus_step);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_wrap_stall();
    test_branch();
    test_jump_vs_branch();
    test_call_ret();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
